io_responder: RTL
=================

// Module: io_responder
// PURPOSE
// - Responder end of the CPU memory bus (address/data/wren/q/stall/IRQ/IRQn). Decodes each CPU
//   access: addresses in the IO page go to local registers, all others pass to the RAM.
// - Hosts GPIO, a down-counting timer and an interrupt controller that drives the CPU IRQ/IRQn inputs.
// - Sits at top level between the CPU, the RAM and board pins.
// PARAMETERS
// - IO_PAGE   8'hFF  address[15:8] value selecting the IO page
// - NUM_IRQ   8      interrupt sources; bit 0 = timer, bits 1..NUM_IRQ-1 = irq_src; range 2..8
// - GPIO_W    8      GPIO width
// PORTS
// - clk        in   1        clock; all state updates on the rising edge
// - nreset     in   1        reset, synchronous, active-low
// - address    in   16       CPU bus address
// - data       in   32       CPU write data
// - wren       in   1        CPU write enable
// - ram_q      in   32       RAM read data
// - q          out  32       read data to CPU
// - ram_wren   out  1        RAM write enable = wren & !io_sel (combinational)
// - stall      out  1        CPU hold request
// - IRQ        out  1        interrupt request to CPU
// - IRQn       out  8        number of the requesting interrupt
// - gpio_out   out  GPIO_W   output register
// - gpio_in    in   GPIO_W   asynchronous inputs
// - irq_src    in   NUM_IRQ-1 asynchronous interrupt lines, rising-edge sensitive
// BEHAVIOUR
// - io_sel = (address[15:8] == IO_PAGE). Offset = address[3:0].
// - Register map, offset 0x0-0x7; 0x8-0xF read 0, writes ignored.
//   - 0x0 GPIO_OUT  RW.
//   - 0x1 GPIO_IN   RO, 2-flop synchronised.
//   - 0x2 TCOUNT    RW.
//   - 0x3 TRELOAD   RW.
//   - 0x4 TCTRL     RW; bit0 EN, bit1 AUTO.
//   - 0x5 PEND      R; write-1-to-clear.
//   - 0x6 ENABLE    RW.
//   - 0x7 ACK       W; clears pending bit data[2:0]; reads return the current IRQn.
// - Writes: io_sel & wren sampled at a rising edge update the register at that edge.
// - Reads:
//   - q is selected by a registered copy of io_sel.
//   - RAM path: q = ram_q, zero added latency.
//   - IO path: read data is registered; q holds it from the edge after sampling.
// - IO read stall FSM, states IDLE and WAIT:
//   - IDLE -> WAIT when io_sel & !wren is sampled while stall is low; stall = 1 for exactly one cycle.
//   - WAIT -> IDLE unconditionally.
//   - Accesses sampled in WAIT are ignored; the CPU holds address while stalled.
//   - IO writes and all RAM accesses never stall.
// - Timer:
//   - When EN=1 and TCOUNT!=0: TCOUNT decrements every cycle.
//   - When EN=1 and TCOUNT==0: set PEND[0]. If AUTO=1, TCOUNT<=TRELOAD. If AUTO=0, EN<=0.
//   - EN=0: TCOUNT holds.
//   - A CPU write to TCOUNT in the same cycle wins: load the written value, no PEND[0] set.
//   - 32-bit wrap-free: never decrements below 0.
// - Interrupt sources:
//   - irq_src[i] passes through a 2-flop sync; a rising edge of the synced signal sets PEND[i+1].
//   - Set beats clear in the same cycle, whether the clear comes from PEND W1C or ACK.
// - Interrupt outputs:
//   - active = PEND & ENABLE.
//   - IRQ (registered) = |active.
//   - IRQn (registered) = index of the lowest set bit of active; lowest index wins.
//   - IRQn holds its last value when active == 0.
// - Reset values: q=0, stall=0, IRQ=0, IRQn=0, gpio_out=0, all registers 0, FSM IDLE,
//   sync flops 0 (no spurious edge after reset).
//   - Reset mid-WAIT returns to IDLE with stall=0 next cycle.
// STRUCTURE
// - Package io_pkg: IO_PAGE default, register offset localparams OFS_GPIO_OUT..OFS_ACK,
//   TCTRL bit positions, FSM state encoding.
// - Sub-module io_timer: TCOUNT/TRELOAD/TCTRL, load and reload logic, 1-cycle expire pulse.
// - Decode, read mux, stall FSM, sync and interrupt logic stay in the top module.
// TESTING
// - Write 0x000000A5 to 0xFF00 -> gpio_out=0xA5 next edge; ram_wren stays 0.
//   Write 0x0000_1234 to 0x0010 -> ram_wren=1 that cycle.
// - Read 0xFF01 with gpio_in=0x3C held -> stall high exactly 1 cycle; q=0x0000003C.
//   Back-to-back RAM read -> no stall.
// - TRELOAD=3, TCOUNT=3, TCTRL=3 -> PEND[0] every 4 cycles; with ENABLE[0]=1, IRQ=1 and IRQn=0.
//   Write ACK 0 -> IRQ=0 within 2 cycles.
// - Set ENABLE=0x06, pulse irq_src[0] and irq_src[1] together -> IRQn=1.
//   ACK 1 -> IRQn=2. ACK 2 -> IRQ=0.
// - Rising edge on irq_src[0] in the same cycle as PEND W1C 0x02 -> PEND[1] remains 1.
// - Timer at 0 with EN=1 while CPU writes TCOUNT=10 -> TCOUNT=10, PEND[0] unchanged.
//   Assert nreset during WAIT -> stall=0, all outputs 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the CPU-bus IO responder.
// Page select default, register offsets, timer control bits, FSM states.
package io_pkg;

    localparam logic [7:0] IO_PAGE_DEF  = 8'hFF;

    localparam logic [3:0] OFS_GPIO_OUT = 4'h0;
    localparam logic [3:0] OFS_GPIO_IN  = 4'h1;
    localparam logic [3:0] OFS_TCOUNT   = 4'h2;
    localparam logic [3:0] OFS_TRELOAD  = 4'h3;
    localparam logic [3:0] OFS_TCTRL    = 4'h4;
    localparam logic [3:0] OFS_PEND     = 4'h5;
    localparam logic [3:0] OFS_ENABLE   = 4'h6;
    localparam logic [3:0] OFS_ACK      = 4'h7;

    localparam int TC_EN   = 0;
    localparam int TC_AUTO = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [7:0] lsb_idx(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 8'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/io_timer.sv
// Down-counting timer: TCOUNT, TRELOAD, TCTRL (EN, AUTO).
// Ports: clk, nreset, wr_en/ofs/wdata (accepted IO write), tcount, treload, tctrl, expire.
module io_timer
    import io_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        wr_en,
    input  logic [3:0]  ofs,
    input  logic [31:0] wdata,
    output logic [31:0] tcount,
    output logic [31:0] treload,
    output logic [1:0]  tctrl,
    output logic        expire
);

    logic wr_cnt;
    logic wr_rld;
    logic wr_ctl;

    assign wr_cnt = wr_en && (ofs == OFS_TCOUNT);
    assign wr_rld = wr_en && (ofs == OFS_TRELOAD);
    assign wr_ctl = wr_en && (ofs == OFS_TCTRL);

    // A CPU load of TCOUNT suppresses the expiry it would otherwise meet.
    assign expire = tctrl[TC_EN] && (tcount == '0) && !wr_cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            tcount  <= '0;
            treload <= '0;
            tctrl   <= '0;
        end else begin
            if (wr_rld) treload <= wdata;

            if (wr_cnt) begin
                tcount <= wdata;
            end else if (tctrl[TC_EN]) begin
                if (tcount != '0) begin
                    tcount <= tcount - 32'd1;
                end else if (tctrl[TC_AUTO]) begin
                    tcount <= treload;
                end
            end

            if (wr_ctl) begin
                tctrl <= wdata[1:0];
            end else if (expire && !tctrl[TC_AUTO]) begin
                tctrl[TC_EN] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// Responder end of the CPU memory bus: IO page decode, GPIO, timer, IRQ controller.
// Ports: CPU bus (address/data/wren/q/stall/IRQ/IRQn), RAM (ram_q/ram_wren), gpio_*, irq_src.
module io_responder
    import io_pkg::*;
#(
    parameter logic [7:0] IO_PAGE = IO_PAGE_DEF,
    parameter int          NUM_IRQ = 8,
    parameter int          GPIO_W  = 8
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [15:0]        address,
    input  logic [31:0]        data,
    input  logic               wren,
    input  logic [31:0]        ram_q,
    output logic [31:0]        q,
    output logic               ram_wren,
    output logic               stall,
    output logic               IRQ,
    output logic [7:0]         IRQn,
    output logic [GPIO_W-1:0]  gpio_out,
    input  logic [GPIO_W-1:0]  gpio_in,
    input  logic [NUM_IRQ-2:0] irq_src
);

    logic        io_sel;
    logic [3:0]  ofs;
    logic        io_wr;
    state_t      state;
    state_t      state_nx;

    logic [GPIO_W-1:0]  gsync1;
    logic [GPIO_W-1:0]  gsync2;
    logic [NUM_IRQ-2:0] isync1;
    logic [NUM_IRQ-2:0] isync2;
    logic [NUM_IRQ-2:0] isync3;

    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] ack_oh;

    logic        sel_q;
    logic [31:0] rdata_q;
    logic [31:0] rd;

    logic [31:0] tcount;
    logic [31:0] treload;
    logic [1:0]  tctrl;
    logic        expire;

    logic        unused;

    assign unused   = ^address[7:4];
    assign io_sel   = (address[15:8] == IO_PAGE);
    assign ofs      = address[3:0];
    assign ram_wren = wren & ~io_sel;
    assign stall    = (state == ST_WAIT);

    // Anything sampled while stalled is the held repeat of the same access.
    assign io_wr = io_sel && wren && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (io_sel && !wren) state_nx = ST_WAIT;
            ST_WAIT: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    io_timer u_timer (
        .clk     (clk),
        .nreset  (nreset),
        .wr_en   (io_wr),
        .ofs     (ofs),
        .wdata   (data),
        .tcount  (tcount),
        .treload (treload),
        .tctrl   (tctrl),
        .expire  (expire)
    );

    always_comb begin
        ack_oh    = '0;
        ack_oh[0] = 1'b1;
        ack_oh    = ack_oh << data[2:0];
    end

    assign pend_set = {isync2 & ~isync3, expire};
    assign active   = pend & enable;

    always_comb begin
        pend_clr = '0;
        if (io_wr && ofs == OFS_PEND) pend_clr = pend_clr | data[NUM_IRQ-1:0];
        if (io_wr && ofs == OFS_ACK)  pend_clr = pend_clr | ack_oh;
    end

    always_comb begin
        rd = '0;
        case (ofs)
            OFS_GPIO_OUT: rd = 32'(gpio_out);
            OFS_GPIO_IN:  rd = 32'(gsync2);
            OFS_TCOUNT:   rd = tcount;
            OFS_TRELOAD:  rd = treload;
            OFS_TCTRL:    rd = 32'(tctrl);
            OFS_PEND:     rd = 32'(pend);
            OFS_ENABLE:   rd = 32'(enable);
            OFS_ACK:      rd = 32'(IRQn);
            default:      rd = '0;
        endcase
    end

    // Reset parks the mux on the cleared IO read register so q starts at 0.
    assign q = sel_q ? rdata_q : ram_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            gsync1   <= '0;
            gsync2   <= '0;
            isync1   <= '0;
            isync2   <= '0;
            isync3   <= '0;
            gpio_out <= '0;
            pend     <= '0;
            enable   <= '0;
            IRQ      <= 1'b0;
            IRQn     <= '0;
            sel_q    <= 1'b1;
            rdata_q  <= '0;
        end else begin
            gsync1 <= gpio_in;
            gsync2 <= gsync1;
            isync1 <= irq_src;
            isync2 <= isync1;
            isync3 <= isync2;

            if (io_wr && ofs == OFS_GPIO_OUT) gpio_out <= data[GPIO_W-1:0];
            if (io_wr && ofs == OFS_ENABLE)   enable   <= data[NUM_IRQ-1:0];

            pend <= (pend & ~pend_clr) | pend_set;

            IRQ <= |active;
            if (|active) IRQn <= lsb_idx(8'(active));

            sel_q   <= io_sel;
            rdata_q <= rd;
        end
    end

endmodule
